// File: rtl/instr_decode_fsm.sv
// Control unit for the 16-bit datapath: holds one instruction in IR and walks
// the register file / A / B / shifter / ALU / C / status controls one state per cycle.
module instr_decode_fsm #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic             w,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic [1:0]       vsel,
  output logic             loada,
  output logic             loadb,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic             loadc,
  output logic             loads,
  output logic [WIDTH-1:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WIMM,
    S_GETA,
    S_GETB,
    S_COMPUTE,
    S_CMPS,
    S_WREG
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] ir;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;
  logic       is_alu;
  logic       is_mov_reg;
  logic       is_mvn;
  logic       is_and;
  logic       is_cmp;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign is_alu     = (opcode == 3'b101);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_and     = is_alu && (op == 2'b10);
  assign is_cmp     = is_alu && (op == 2'b01);

  assign sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};

  // IR only opens in WAIT, so it stays frozen while an instruction runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_WAIT && load) begin
        ir <= in;
      end
    end
  end

  always_comb begin
    next_state = state;
    w          = 1'b0;
    readnum    = 3'd0;
    writenum   = 3'd0;
    write      = 1'b0;
    vsel       = 2'b00;
    loada      = 1'b0;
    loadb      = 1'b0;
    asel       = 1'b1;
    bsel       = 1'b0;
    shift      = 2'b00;
    ALUop      = 2'b00;
    loadc      = 1'b0;
    loads      = 1'b0;

    case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) next_state = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == 3'b110 && op == 2'b10)      next_state = S_WIMM;
        else if (is_mov_reg)                      next_state = S_GETB;
        else if (is_alu && op != 2'b11)           next_state = S_GETA;
        else if (is_mvn)                          next_state = S_GETB;
        else                                      next_state = S_WAIT;
      end
      S_WIMM: begin
        writenum   = rn;
        vsel       = 2'b10;
        write      = 1'b1;
        next_state = S_WAIT;
      end
      S_GETA: begin
        readnum    = rn;
        loada      = 1'b1;
        next_state = S_GETB;
      end
      S_GETB: begin
        readnum    = rm;
        loadb      = 1'b1;
        next_state = is_cmp ? S_CMPS : S_COMPUTE;
      end
      S_COMPUTE: begin
        shift      = sh;
        loadc      = 1'b1;
        // MOV-reg and MVN feed zero on the A side so only B reaches the result.
        asel       = !(is_mov_reg || is_mvn);
        if (is_mvn)      ALUop = 2'b11;
        else if (is_and) ALUop = 2'b10;
        else             ALUop = 2'b00;
        next_state = S_WREG;
      end
      S_CMPS: begin
        shift      = sh;
        ALUop      = 2'b01;
        loads      = 1'b1;
        next_state = S_WAIT;
      end
      S_WREG: begin
        writenum   = rd;
        write      = 1'b1;
        next_state = S_WAIT;
      end
      default: next_state = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_instr_decode_fsm.sv
// Bench for instr_decode_fsm: a spec-level model pushes the expected per-cycle
// control vector for each instruction into a queue; each clock pops and compares.
module tb_instr_decode_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s = 1'b0;
  logic        load = 1'b0;
  logic [15:0] in = '0;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic        loadc;
  logic        loads;
  logic [15:0] sximm8;

  instr_decode_fsm #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift),
    .ALUop(ALUop), .loadc(loadc), .loads(loads), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  localparam int ST_WAIT = 0, ST_DECODE = 1, ST_WIMM = 2, ST_GETA = 3,
                 ST_GETB = 4, ST_COMPUTE = 5, ST_CMPS = 6, ST_WREG = 7;

  int          compared = 0;
  int          mismatched = 0;
  int          exp_writes = 0;
  logic [19:0] exp_q[$];
  int          st_q[$];
  logic [19:0] act_vec;

  assign act_vec = {w, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
                    shift, ALUop, loadc, loads};

  // Control vector the spec calls for in state st with instruction ir.
  function automatic logic [19:0] exp_vec(input int st, input logic [15:0] ir);
    logic       ew, ewr, ela, elb, eas, ebs, elc, els;
    logic [2:0] ern, ewn;
    logic [1:0] evs, esh, eop;
    ew = 0; ewr = 0; ela = 0; elb = 0; eas = 1; ebs = 0; elc = 0; els = 0;
    ern = 0; ewn = 0; evs = 0; esh = 0; eop = 0;
    case (st)
      ST_WAIT:  ew = 1;
      ST_WIMM:  begin ewn = ir[10:8]; evs = 2'b10; ewr = 1; end
      ST_GETA:  begin ern = ir[10:8]; ela = 1; end
      ST_GETB:  begin ern = ir[2:0]; elb = 1; end
      ST_COMPUTE: begin
        esh = ir[4:3]; elc = 1;
        if (ir[15:13] == 3'b110)      begin eas = 0; eop = 2'b00; end
        else if (ir[12:11] == 2'b11)  begin eas = 0; eop = 2'b11; end
        else if (ir[12:11] == 2'b10)  eop = 2'b10;
        else                          eop = 2'b00;
      end
      ST_CMPS:  begin esh = ir[4:3]; eop = 2'b01; els = 1; end
      ST_WREG:  begin ewn = ir[7:5]; ewr = 1; end
      default: ;
    endcase
    return {ew, ern, ewn, ewr, evs, ela, elb, eas, ebs, esh, eop, elc, els};
  endfunction

  task automatic push_state(input int st, input logic [15:0] ir);
    st_q.push_back(st);
    exp_q.push_back(exp_vec(st, ir));
    if (st == ST_WIMM || st == ST_WREG) exp_writes++;
  endtask

  // Expected state walk after the WAIT edge that samples s=1.
  task automatic push_expected(input logic [15:0] ir);
    logic [2:0] opc;
    logic [1:0] o;
    opc = ir[15:13];
    o   = ir[12:11];
    push_state(ST_DECODE, ir);
    if (opc == 3'b110 && o == 2'b10) begin
      push_state(ST_WIMM, ir);
    end else if (opc == 3'b110 && o == 2'b00) begin
      push_state(ST_GETB, ir); push_state(ST_COMPUTE, ir); push_state(ST_WREG, ir);
    end else if (opc == 3'b101 && o == 2'b01) begin
      push_state(ST_GETA, ir); push_state(ST_GETB, ir); push_state(ST_CMPS, ir);
    end else if (opc == 3'b101 && o == 2'b11) begin
      push_state(ST_GETB, ir); push_state(ST_COMPUTE, ir); push_state(ST_WREG, ir);
    end else if (opc == 3'b101) begin
      push_state(ST_GETA, ir); push_state(ST_GETB, ir);
      push_state(ST_COMPUTE, ir); push_state(ST_WREG, ir);
    end
    push_state(ST_WAIT, ir);
  endtask

  // Drain the queue one clock per entry; s stays high until the last WAIT if hold_s.
  task automatic drain(input logic [15:0] ir, input bit hold_s, input bit inject,
                       output int writes);
    logic [19:0] e;
    int          st;
    int          step;
    writes = 0;
    step   = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      step++;
      load = 1'b0;
      e  = exp_q.pop_front();
      st = st_q.pop_front();
      s  = hold_s && (exp_q.size() > 0);
      compared++;
      if (act_vec !== e) begin
        mismatched++;
        $display("FAIL ctrl ir=%h edge=%0d state=%0d: got %b required %b", ir, step, st, act_vec, e);
      end
      if (write) writes++;
      if (inject && st == ST_GETB) begin
        load = 1'b1;
        in   = 16'hD101;
      end
    end
    s = 1'b0;
  endtask

  task automatic run_instr(input logic [15:0] ir, input bit same_edge, input bit inject);
    int          writes;
    logic [15:0] exp_sx;
    if (!same_edge) begin
      load = 1'b1; in = ir;
      @(posedge clk); #1;
      load = 1'b0;
    end
    load = same_edge; in = ir; s = 1'b1;
    exp_writes = 0;
    push_expected(ir);
    drain(ir, 1'b0, inject, writes);
    exp_sx = {{8{ir[7]}}, ir[7:0]};
    compared++;
    if (sximm8 !== exp_sx) begin
      mismatched++;
      $display("FAIL sximm8 ir=%h: got %h required %h", ir, sximm8, exp_sx);
    end
    compared++;
    if (writes !== exp_writes) begin
      mismatched++;
      $display("FAIL write_count ir=%h: got %0d required %0d", ir, writes, exp_writes);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; #1;
    compared++;
    if (act_vec !== exp_vec(ST_WAIT, 16'h0) || sximm8 !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_state: got %b/%h required %b/0000", act_vec, sximm8, exp_vec(ST_WAIT, 16'h0));
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (act_vec !== exp_vec(ST_WAIT, 16'h0)) begin
      mismatched++;
      $display("FAIL reset_idle: got %b required %b", act_vec, exp_vec(ST_WAIT, 16'h0));
    end
  endtask

  task automatic test_mov_imm;
    run_instr(16'hD207, 1'b0, 1'b0);
    run_instr(16'hD2F9, 1'b1, 1'b0);
  endtask

  task automatic test_alu;
    run_instr(16'hA1A8, 1'b0, 1'b0);  // ADD R5,R1,R0 LSL#1
    run_instr(16'hA902, 1'b0, 1'b0);  // CMP R1,R2
    run_instr(16'hB0C9, 1'b0, 1'b0);  // AND R6,R0,R1 LSL#1
    run_instr(16'hC0A1, 1'b0, 1'b0);  // MOV R5,R1
  endtask

  task automatic test_load_ignored;
    run_instr(16'hB8E3, 1'b0, 1'b1);  // MVN R7,R3 with a stray load in GETB
  endtask

  task automatic test_back_to_back;
    int writes;
    logic [15:0] ir;
    ir = 16'hE000;
    for (int k = 0; k < 2; k++) begin
      load = 1'b1; in = ir;
      @(posedge clk); #1;
      load = 1'b0; s = 1'b1;
      exp_writes = 0;
      push_expected(ir);
      push_expected(ir);
      drain(ir, 1'b1, 1'b0, writes);
      compared++;
      if (writes !== exp_writes) begin
        mismatched++;
        $display("FAIL b2b_writes ir=%h: got %0d required %0d", ir, writes, exp_writes);
      end
      ir = 16'hD203;
    end
  endtask

  task automatic test_reset_mid;
    int edges;
    load = 1'b1; in = 16'hA1A8;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b1;
    edges = 0;
    while (!(loadc === 1'b1) && edges < 10) begin
      @(posedge clk); #1;
      s = 1'b0;
      edges++;
    end
    compared++;
    if (edges !== 4) begin
      mismatched++;
      $display("FAIL reach_compute: got %0d edges required 4", edges);
    end
    #2 reset = 1'b1; #1;
    compared++;
    if (act_vec !== exp_vec(ST_WAIT, 16'h0) || sximm8 !== 16'h0) begin
      mismatched++;
      $display("FAIL async_reset: got %b/%h required %b/0000", act_vec, sximm8, exp_vec(ST_WAIT, 16'h0));
    end
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (act_vec !== exp_vec(ST_WAIT, 16'h0)) begin
      mismatched++;
      $display("FAIL post_reset_no_wreg: got %b required %b", act_vec, exp_vec(ST_WAIT, 16'h0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset;
    test_mov_imm;
    test_alu;
    test_load_ignored;
    test_back_to_back;
    test_reset_mid;
    for (int i = 0; i < 6; i++) begin
      logic [15:0] r;
      r = 16'($urandom_range(0, 16'hFFFF));
      run_instr(r, 1'($urandom_range(0, 1)), 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_decode_fsm.md
Name: instr_decode_fsm

Overview:
- Control unit that sequences the 16-bit datapath: register file, A/B load registers, shifter, ALU, and the C/status registers.
- Latches one instruction and decodes it.
- Drives every datapath control (readnum/writenum, vsel, loada, loadb, asel, bsel, shift, ALUop, loadc, loads, write) one state per cycle.
- Signals completion to the top level via w.

Parameters:
- WIDTH, 16, instruction and immediate width (fixed encoding fields below assume 16).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- s  in  1  start: begin executing the held instruction
- load  in  1  capture in into instruction register (IR)
- in  in  WIDTH  instruction word
- w  out  1  1 while idle in WAIT, ready for s/load
- readnum  out  3  register file read index
- writenum  out  3  register file write index
- write  out  1  register file write enable
- vsel  out  2  writeback select: 00=C, 10=sximm8 (01, 11 never driven)
- loada  out  1  load A from register file
- loadb  out  1  load B from register file
- asel  out  1  1=A to ALU, 0=zero to ALU
- bsel  out  1  0=shifted B to ALU, 1=immediate
- shift  out  2  shifter op
- ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B
- loadc  out  1  capture ALU result into C
- loads  out  1  capture zero flag into status
- sximm8  out  WIDTH  sign-extended IR[7:0]

Behaviour:
- Reset (async, asserted): state=WAIT, IR=0. While in WAIT: w=1; write, loada, loadb, loadc, loads=0; vsel=00; asel=1; bsel=0; shift=00; ALUop=00; readnum=writenum=0.
- IR encoding:
  - opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
  - sximm8 = {8{IR[7]}, IR[7:0]}, combinational from IR at all times.
- IR capture:
  - IR<=in on a clock edge with load=1 only while state=WAIT.
  - load in any other state is ignored; IR stays stable for the whole instruction.
  - If load and s are both high in WAIT, IR captures and the FSM leaves WAIT on the same edge, so the new instruction executes.
- Outputs are Moore, decoded from state and IR. Every unspecified control is 0 / its WAIT value.
- States: WAIT, DECODE, WIMM, GETA, GETB, COMPUTE, CMPS, WREG.
- Transitions:
  - WAIT: s=1 -> DECODE; else stay. w=1 only here.
  - DECODE (no controls asserted):
    - opcode 110, op 10 -> WIMM
    - opcode 110, op 00 -> GETB
    - opcode 101, op 00/01/10 -> GETA
    - opcode 101, op 11 -> GETB
    - any other opcode/op -> WAIT (NOP, no writes).
  - WIMM: writenum=Rn, vsel=10, write=1 -> WAIT.
  - GETA: readnum=Rn, loada=1 -> GETB.
  - GETB: readnum=Rm, loadb=1 -> COMPUTE if the instruction is ADD, AND, MVN or MOV-reg; CMPS if CMP.
  - COMPUTE: shift=sh, bsel=0, loadc=1.
    - MOV-reg: asel=0, ALUop=00.
    - ADD: asel=1, ALUop=00.
    - AND: asel=1, ALUop=10.
    - MVN: asel=0, ALUop=11.
    - Next -> WREG.
  - CMPS: shift=sh, asel=1, bsel=0, ALUop=01, loads=1, loadc=0 -> WAIT.
  - WREG: writenum=Rd, vsel=00, write=1 -> WAIT.
- Latency (edges from the WAIT edge sampling s=1 to w=1 again):
  - MOV imm: 3
  - MOV reg, MVN: 5
  - ADD, AND: 6
  - CMP: 5
  - NOP: 2
- s held high continuously: each pass through WAIT lasts exactly one cycle; the same IR re-executes back-to-back.
- s in any non-WAIT state is ignored.
- Reset asserted mid-instruction: immediate return to WAIT and IR=0; a pending write never occurs after reset assertion.
- write, loadc and loads are never asserted in the same cycle; exactly one write pulse per writing instruction.

Test Plan:
- Reset, load in=16'hD207 (MOV R2,#7), pulse s -> DECODE, WIMM (writenum=2, vsel=10, write=1, sximm8=16'h0007), w=1 on 3rd edge; in=16'hD2F9 gives sximm8=16'hFFF9.
- IR=16'hA1A8 (ADD R5,R1,R0 LSL#1) -> GETA readnum=1 loada; GETB readnum=0 loadb; COMPUTE shift=01 asel=1 ALUop=00 loadc; WREG writenum=5 write; w after 6 edges.
- IR=16'hA902 (CMP R1,R2) -> COMPUTE-phase is CMPS with ALUop=01 loads=1, loadc=0, write never asserted; w after 5 edges.
- IR=16'hB8E3 (MVN R7,R3) -> no GETA; COMPUTE asel=0 ALUop=11; WREG writenum=7; load=1 with in=16'hD101 during GETB leaves IR=16'hB8E3.
- IR=16'hE000 (undefined) -> DECODE then WAIT, zero write/loadc/loads pulses; s held high 4 cycles re-executes, w toggles 1,0,1,0.
- ADD in progress, assert reset during COMPUTE -> same-cycle async state=WAIT, w=1, IR=0, no WREG write observed.
